// File: rtl/bus_timer_slave.sv
// ============================================================================
// Module   : bus_timer_slave
// Purpose  : Bus-slave interval timer with programmable wait states and IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_timer_slave #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq
);

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_rw;
    logic [1:0]  r_addr;
    logic [31:0] r_rd_hold;
    logic [31:0] r_rd_data;
    logic        r_rdy_n;

    logic        r_start;
    logic        r_periodic;
    logic        r_expired;
    logic [31:0] r_expr;
    logic [31:0] r_counter;

    logic        w_accept;
    logic        w_wr;
    logic        w_expire;
    logic [1:0]  w_sel_addr;
    logic [31:0] w_rd_mux;

    assign w_accept   = (r_state == ST_IDLE) && !cs_ && !as_;
    assign w_wr       = w_accept && !rw;
    assign w_expire   = r_start && (r_counter == r_expr);
    // With no wait states the ACK entry edge is the accept edge itself
    assign w_sel_addr = (r_state == ST_IDLE) ? addr : r_addr;

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_sel_addr)
            2'd0:    w_rd_mux = {30'd0, r_periodic, r_start};
            2'd1:    w_rd_mux = {31'd0, r_expired};
            2'd2:    w_rd_mux = r_expr;
            default: w_rd_mux = r_counter;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_rw       <= 1'b0;
            r_addr     <= 2'd0;
            r_rd_hold  <= 32'd0;
            r_rd_data  <= 32'd0;
            r_rdy_n    <= 1'b1;
        end else begin
            r_rdy_n   <= 1'b1;
            r_rd_data <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rw   <= rw;
                        r_addr <= addr;
                        if (c_WAIT != 4'd0) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= c_WAIT;
                        end else begin
                            r_state   <= ST_ACK;
                            r_rd_hold <= w_rd_mux;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt <= 4'd1) begin
                        r_state    <= ST_ACK;
                        r_wait_cnt <= 4'd0;
                        r_rd_hold  <= w_rd_mux;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    r_rdy_n   <= 1'b0;
                    r_rd_data <= r_rw ? r_rd_hold : 32'd0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus writes beat the timer, except that an expiration always sets the flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start    <= 1'b0;
            r_periodic <= 1'b0;
            r_expired  <= 1'b0;
            r_expr     <= 32'd0;
            r_counter  <= 32'd0;
        end else begin
            if (w_wr && addr == 2'd0) begin
                r_start    <= wr_data[0];
                r_periodic <= wr_data[1];
            end else if (w_expire && !r_periodic) begin
                r_start <= 1'b0;
            end

            if (w_expire)
                r_expired <= 1'b1;
            else if (w_wr && addr == 2'd1)
                r_expired <= wr_data[0];

            if (w_wr && addr == 2'd2)
                r_expr <= wr_data;

            if (w_wr && addr == 2'd3)
                r_counter <= wr_data;
            else if (w_expire)
                r_counter <= 32'd0;
            else if (r_start)
                r_counter <= r_counter + 32'd1;
        end
    end

    assign rd_data = r_rd_data;
    assign rdy_    = r_rdy_n;
    assign irq     = r_expired;

endmodule

`default_nettype wire

// File: tb/tb_bus_timer_slave.sv
// ============================================================================
// Module   : tb_bus_timer_slave
// Purpose  : Drives two timer slaves (0 and 3 wait states) against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_timer_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs0_, cs3_, as_, rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3, irq0, irq3;

    int n_total = 0;
    int n_pass  = 0;

    bit          m_start, m_per, m_exp;
    logic [31:0] m_expr, m_cnt;
    bit          p_wr;
    logic [1:0]  p_addr;
    logic [31:0] p_data;

    bus_timer_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .cs_(cs0_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd0), .rdy_(rdy0), .irq(irq0)
    );

    bus_timer_slave #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .cs_(cs3_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd3), .rdy_(rdy3), .irq(irq3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mread(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_per, m_start};
            2'd1:    return {31'd0, m_exp};
            2'd2:    return m_expr;
            default: return m_cnt;
        endcase
    endfunction

    task automatic mclear();
        m_start = 0; m_per = 0; m_exp = 0; m_expr = '0; m_cnt = '0; p_wr = 0;
    endtask

    // One clock: the model applies the timer rules to its own register set
    task automatic step();
        bit          e, n_start, n_per, n_exp;
        logic [31:0] n_cnt, n_expr;
        e       = m_start && (m_cnt == m_expr);
        n_start = m_start;
        n_per   = m_per;
        if (p_wr && p_addr == 2'd0) begin
            n_start = p_data[0];
            n_per   = p_data[1];
        end else if (e && !m_per) begin
            n_start = 0;
        end
        n_exp  = e | ((p_wr && p_addr == 2'd1) ? p_data[0] : m_exp);
        n_expr = (p_wr && p_addr == 2'd2) ? p_data : m_expr;
        if (p_wr && p_addr == 2'd3) n_cnt = p_data;
        else if (e)                 n_cnt = 32'd0;
        else if (m_start)           n_cnt = m_cnt + 32'd1;
        else                        n_cnt = m_cnt;
        @(posedge clk);
        #1;
        if (reset) begin
            m_start = n_start; m_per = n_per; m_exp = n_exp;
            m_expr = n_expr; m_cnt = n_cnt;
        end else begin
            mclear();
        end
        p_wr = 0;
        chk("irq0", {31'd0, irq0}, {31'd0, m_exp});
        chk("irq3", {31'd0, irq3}, {31'd0, m_exp});
    endtask

    task automatic bus_idle();
        cs0_ = 1; cs3_ = 1; as_ = 1; rw = 1; addr = 2'($urandom); wr_data = $urandom;
    endtask

    // One access seen by both slaves; latency and read data checked on each
    task automatic access(input logic w_rw, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] e0, e3;
        cs0_ = 0; cs3_ = 0; as_ = 0; rw = w_rw; addr = a; wr_data = d;
        e0 = mread(a);
        if (!w_rw) begin p_wr = 1; p_addr = a; p_data = d; end
        step();
        bus_idle();
        step();
        chk("rdy0_low", {31'd0, rdy0}, 32'd0);
        if (w_rw) chk("rd0_data", rd0, e0);
        chk("rdy3_early", {31'd0, rdy3}, 32'd1);
        step();
        chk("rdy0_one_cycle", {31'd0, rdy0}, 32'd1);
        chk("rd0_idle_zero", rd0, 32'd0);
        e3 = mread(a);
        step();
        chk("rdy3_wait", {31'd0, rdy3}, 32'd1);
        step();
        chk("rdy3_low", {31'd0, rdy3}, 32'd0);
        if (w_rw) chk("rd3_data", rd3, e3);
        step();
        chk("rdy3_one_cycle", {31'd0, rdy3}, 32'd1);
        chk("rd3_idle_zero", rd3, 32'd0);
    endtask

    initial begin
        logic [31:0] x, y;
        int pulses, guard;
        mclear();
        bus_idle();
        reset = 0;
        #12;
        chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
        chk("rst_rd3", rd3, 32'd0);
        step();
        reset = 1;

        // Read latency on both wait-state settings
        access(0, 2'd2, 32'h0000_1234);
        access(1, 2'd2, 32'hDEAD_BEEF);

        // One-shot run
        access(0, 2'd2, 32'd5);
        access(0, 2'd3, 32'd0);
        access(0, 2'd0, 32'h1);
        for (int i = 0; i < 4; i++) step();
        access(1, 2'd3, 32'd0);
        access(1, 2'd0, 32'd0);
        access(1, 2'd1, 32'd0);
        access(0, 2'd1, 32'd0);

        // Periodic run, clear away from and on an expiration
        access(0, 2'd2, 32'd3);
        access(0, 2'd0, 32'h3);
        guard = 0;
        while (m_cnt != 32'd1 && guard < 20) begin step(); guard++; end
        access(0, 2'd1, 32'd0);
        guard = 0;
        while (m_cnt != 32'd3 && guard < 20) begin step(); guard++; end
        access(0, 2'd1, 32'd0);
        chk("clear_on_expire_irq", {31'd0, irq0}, {31'd0, m_exp});
        access(0, 2'd0, 32'd0);

        // Write colliding with an increment near the top of the range
        access(0, 2'd2, 32'hFFFF_FFFF);
        access(0, 2'd0, 32'h1);
        access(0, 2'd3, 32'hFFFF_FFFE);
        access(1, 2'd3, 32'd0);
        access(1, 2'd1, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: for (int k = $urandom_range(1, 6); k > 0; k--) step();
                1: access(1, 2'($urandom), 32'd0);
                2: access(0, 2'($urandom_range(2, 3)), $urandom_range(0, 9));
                default: access(0, 2'($urandom_range(0, 1)), $urandom);
            endcase
        end

        // Second strobe during wait states must be dropped by the slow slave
        access(0, 2'd0, 32'd0);
        x = $urandom; y = ~x;
        cs0_ = 0; cs3_ = 0; as_ = 0; rw = 0; addr = 2'd2; wr_data = x;
        p_wr = 1; p_addr = 2'd2; p_data = x;
        step();
        bus_idle();
        step();
        cs3_ = 0; as_ = 0; rw = 0; addr = 2'd2; wr_data = y;
        step();
        pulses = (rdy3 == 1'b0) ? 1 : 0;
        bus_idle();
        for (int k = 0; k < 6; k++) begin
            step();
            if (rdy3 == 1'b0) pulses++;
        end
        chk("ignored_strobe_pulses", pulses, 1);
        access(1, 2'd2, 32'd0);

        // Reset in the middle of a waited access
        access(0, 2'd2, 32'd2);
        access(0, 2'd0, 32'h3);
        for (int k = 0; k < 5; k++) step();
        cs0_ = 0; cs3_ = 0; as_ = 0; rw = 1; addr = 2'd3;
        step();
        bus_idle();
        step();
        #2;
        reset = 0;
        mclear();
        #1;
        chk("midrst_rdy3", {31'd0, rdy3}, 32'd1);
        chk("midrst_rd3", rd3, 32'd0);
        chk("midrst_rdy0", {31'd0, rdy0}, 32'd1);
        chk("midrst_irq", {31'd0, irq3}, 32'd0);
        step();
        step();
        reset = 1;
        for (int a = 0; a < 4; a++) access(1, 2'(a), 32'd0);
        chk("post_rst_counter", mread(2'd3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
